// File: rtl/coffee_dispenser.sv
// Sequences cup/grind/water/milk actuators for one-cycle drink strobes; 1-cycle request-to-cup latency, Moore outputs.
// No backpressure: a one-deep pending slot absorbs a mid-brew request, further requests are dropped with an overflow pulse.
// Optional macro CUP_SENSE_EN adds a cup_present interlock on the cup phase with a timeout fault.
module coffee_dispenser #(
    parameter int CNT_W       = 8,
    parameter int CUP_CYC     = 2,
    parameter int GRIND_CYC   = 3,
    parameter int WATER_SHORT = 4,
    parameter int WATER_LONG  = 8,
    parameter int MILK_CYC    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       exprr,
    input  logic       expr_l,
    input  logic       capp,
`ifdef CUP_SENSE_EN
    input  logic       cup_present,
    output logic       fault,
`endif
    output logic       busy,
    output logic       cup_drop,
    output logic       grind,
    output logic       pump_water,
    output logic       pump_milk,
    output logic [1:0] drink,
    output logic       done,
    output logic       overflow
);

    typedef enum logic [2:0] {IDLE, CUP, GRIND, WATER, MILK, DONE} state_t;

    localparam logic [1:0] D_LONG = 2'b10;
    localparam logic [1:0] D_CAPP = 2'b11;

    localparam logic [CNT_W-1:0] CUP_LD   = CNT_W'(CUP_CYC - 1);
    localparam logic [CNT_W-1:0] GRIND_LD = CNT_W'(GRIND_CYC - 1);
    localparam logic [CNT_W-1:0] WS_LD    = CNT_W'(WATER_SHORT - 1);
    localparam logic [CNT_W-1:0] WL_LD    = CNT_W'(WATER_LONG - 1);
    localparam logic [CNT_W-1:0] MILK_LD  = CNT_W'(MILK_CYC - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       code, code_nx;
    logic [1:0]       pend, pend_nx;
    logic             pend_vld, pend_vld_nx;
    logic             ovf_nx;
    logic [1:0]       req_code;
    logic             req;

`ifdef CUP_SENSE_EN
    localparam logic [CNT_W:0] WAIT_MAX = {1'b1, {CNT_W{1'b0}}};
    logic [CNT_W:0] wait_cnt, wait_cnt_nx;
    logic           fault_nx;
`endif

    // Priority capp > expr_l > exprr; losers are discarded.
    always_comb begin
        req_code = 2'b00;
        if (capp)
            req_code = 2'b11;
        else if (expr_l)
            req_code = 2'b10;
        else if (exprr)
            req_code = 2'b01;
    end
    assign req = (req_code != 2'b00);

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        code_nx     = code;
        pend_nx     = pend;
        pend_vld_nx = pend_vld;
        ovf_nx      = 1'b0;
`ifdef CUP_SENSE_EN
        wait_cnt_nx = wait_cnt;
        fault_nx    = 1'b0;
`endif
        case (state)
            IDLE: begin
                // A pending entry here only survives a cup fault; it goes first.
                if (pend_vld) begin
                    code_nx     = pend;
                    cnt_nx      = CUP_LD;
                    state_nx    = CUP;
                    pend_vld_nx = req;
                    pend_nx     = req_code;
                end else if (req) begin
                    code_nx  = req_code;
                    cnt_nx   = CUP_LD;
                    state_nx = CUP;
                end
            end
            CUP: begin
`ifdef CUP_SENSE_EN
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else if (cup_present) begin
                    cnt_nx      = GRIND_LD;
                    state_nx    = GRIND;
                    wait_cnt_nx = '0;
                end else if (wait_cnt == WAIT_MAX) begin
                    fault_nx    = 1'b1;
                    state_nx    = IDLE;
                    wait_cnt_nx = '0;
                end else begin
                    wait_cnt_nx = wait_cnt + 1'b1;
                end
`else
                if (cnt == '0) begin
                    cnt_nx   = GRIND_LD;
                    state_nx = GRIND;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
`endif
            end
            GRIND: begin
                if (cnt == '0) begin
                    cnt_nx   = (code == D_LONG) ? WL_LD : WS_LD;
                    state_nx = WATER;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            WATER: begin
                if (cnt == '0) begin
                    if (code == D_CAPP) begin
                        cnt_nx   = MILK_LD;
                        state_nx = MILK;
                    end else begin
                        state_nx = DONE;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            MILK: begin
                if (cnt == '0)
                    state_nx = DONE;
                else
                    cnt_nx = cnt - 1'b1;
            end
            DONE: begin
                // Chain straight into the next drink so busy stays high.
                if (pend_vld) begin
                    code_nx     = pend;
                    cnt_nx      = CUP_LD;
                    state_nx    = CUP;
                    pend_vld_nx = req;
                    pend_nx     = req_code;
                end else if (req) begin
                    code_nx  = req_code;
                    cnt_nx   = CUP_LD;
                    state_nx = CUP;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (req && state != IDLE && state != DONE) begin
            if (!pend_vld) begin
                pend_vld_nx = 1'b1;
                pend_nx     = req_code;
            end else begin
                ovf_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            code     <= 2'b00;
            pend     <= 2'b00;
            pend_vld <= 1'b0;
            overflow <= 1'b0;
`ifdef CUP_SENSE_EN
            wait_cnt <= '0;
            fault    <= 1'b0;
`endif
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            code     <= code_nx;
            pend     <= pend_nx;
            pend_vld <= pend_vld_nx;
            overflow <= ovf_nx;
`ifdef CUP_SENSE_EN
            wait_cnt <= wait_cnt_nx;
            fault    <= fault_nx;
`endif
        end
    end

    assign busy       = (state != IDLE);
    assign cup_drop   = (state == CUP);
    assign grind      = (state == GRIND);
    assign pump_water = (state == WATER);
    assign pump_milk  = (state == MILK);
    assign done       = (state == DONE);
    assign drink      = (state == IDLE) ? 2'b00 : code;

endmodule

// File: tb/tb_coffee_dispenser.sv
// Randomized and directed bench for coffee_dispenser, scored against a timeline model of each drink.
module tb_coffee_dispenser;

    localparam int C  = 2;
    localparam int G  = 3;
    localparam int WS = 4;
    localparam int WL = 8;
    localparam int M  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       exprr = 1'b0, expr_l = 1'b0, capp = 1'b0;
    logic       busy, cup_drop, grind, pump_water, pump_milk, done, overflow;
    logic [1:0] drink;
`ifdef CUP_SENSE_EN
    logic       cup_present = 1'b1;
    logic       fault;
`endif

    coffee_dispenser #(
        .CNT_W(8), .CUP_CYC(C), .GRIND_CYC(G),
        .WATER_SHORT(WS), .WATER_LONG(WL), .MILK_CYC(M)
    ) dut (
        .clk(clk), .rst(rst),
        .exprr(exprr), .expr_l(expr_l), .capp(capp),
`ifdef CUP_SENSE_EN
        .cup_present(cup_present), .fault(fault),
`endif
        .busy(busy), .cup_drop(cup_drop), .grind(grind),
        .pump_water(pump_water), .pump_milk(pump_milk),
        .drink(drink), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int busy_run = 0;
    int ovf_seen = 0;

    // Model: active drink (0 = none), elapsed cycles within it, pending drink, overflow due next cycle.
    int m_act = 0;
    int m_el = 0;
    int m_pend = 0;
    int m_ovf = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int water_len(input int code);
        return (code == 2) ? WL : WS;
    endfunction

    function automatic int total_len(input int code);
        return C + G + water_len(code) + ((code == 3) ? M : 0) + 1;
    endfunction

    function automatic logic [31:0] dut_vec();
        return {23'd0, busy, cup_drop, grind, pump_water, pump_milk, drink, done, overflow};
    endfunction

    function automatic logic [31:0] model_vec();
        logic b, cu, g, wa, mi, dn;
        logic [1:0] dk;
        int t, w;
        b = 0; cu = 0; g = 0; wa = 0; mi = 0; dn = 0; dk = 2'b00;
        if (m_act != 0) begin
            t  = total_len(m_act);
            w  = water_len(m_act);
            b  = 1;
            dk = 2'(m_act);
            cu = (m_el < C);
            g  = (m_el >= C) && (m_el < C + G);
            wa = (m_el >= C + G) && (m_el < C + G + w);
            mi = (m_el >= C + G + w) && (m_el < t - 1);
            dn = (m_el == t - 1);
        end
        return {23'd0, b, cu, g, wa, mi, dk, dn, (m_ovf != 0)};
    endfunction

    task automatic model_step(input logic e, input logic l, input logic c);
        int req;
        req = c ? 3 : (l ? 2 : (e ? 1 : 0));
        m_ovf = 0;
        if (m_act == 0) begin
            if (req != 0) begin
                m_act = req;
                m_el  = 0;
            end
        end else if (m_el == total_len(m_act) - 1) begin
            if (m_pend != 0) begin
                m_act  = m_pend;
                m_pend = req;
                m_el   = 0;
            end else if (req != 0) begin
                m_act = req;
                m_el  = 0;
            end else begin
                m_act = 0;
            end
        end else begin
            m_el++;
            if (req != 0) begin
                if (m_pend == 0) m_pend = req;
                else m_ovf = 1;
            end
        end
    endtask

    // Check the current cycle, then apply strobes for the next edge.
    task automatic cycle(input logic e, input logic l, input logic c);
        @(negedge clk);
        check("outs", dut_vec(), model_vec());
        if (busy) busy_run++;
        if (overflow) ovf_seen++;
        exprr  = e;
        expr_l = l;
        capp   = c;
        model_step(e, l, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_now();
        @(negedge clk);
        exprr = 1'b0; expr_l = 1'b0; capp = 1'b0;
        rst = 1'b1;
        #1;
        check("reset", dut_vec(), 32'd0);
        m_act = 0; m_el = 0; m_pend = 0; m_ovf = 0;
        #1 rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_init", dut_vec(), 32'd0);
        rst = 1'b0;

        // Espresso: 10 busy cycles.
        busy_run = 0;
        cycle(1'b1, 1'b0, 1'b0); idle(14);
        check("esp_busy", busy_run, 10);

        // Cappuccino: 15 busy cycles.
        busy_run = 0;
        cycle(1'b0, 1'b0, 1'b1); idle(18);
        check("capp_busy", busy_run, 15);

        // Simultaneous exprr+capp serves cappuccino.
        busy_run = 0;
        cycle(1'b1, 1'b0, 1'b1); idle(18);
        check("prio_busy", busy_run, 15);

        // Long espresso: 14 busy cycles.
        busy_run = 0;
        cycle(1'b0, 1'b1, 1'b0); idle(17);
        check("long_busy", busy_run, 14);

        // Pending fill then overflow; second drink chains with busy unbroken.
        busy_run = 0; ovf_seen = 0;
        cycle(1'b1, 1'b0, 1'b0); idle(2);
        cycle(1'b0, 1'b1, 1'b0); idle(3);
        cycle(1'b0, 1'b0, 1'b1); idle(30);
        check("chain_busy", busy_run, 24);
        check("chain_ovf", ovf_seen, 1);

        // Reset in the middle of the milk phase, then a clean restart.
        cycle(1'b0, 1'b0, 1'b1); idle(11);
        check("in_milk", pump_milk, 1'b1);
        reset_now();
        busy_run = 0;
        cycle(1'b1, 1'b0, 1'b0); idle(14);
        check("restart_busy", busy_run, 10);

        // Randomized strobes, including simultaneous ones.
        for (int i = 0; i < 3000; i++) begin
            logic e, l, c;
            e = ($urandom_range(0, 9) == 0);
            l = ($urandom_range(0, 11) == 0);
            c = ($urandom_range(0, 13) == 0);
            cycle(e, l, c);
            if ($urandom_range(0, 999) == 0) reset_now();
        end
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/coffee_dispenser.md
Name: coffee_dispenser

Overview:
Actuator-side responder to the coffee vending controller's one-cycle drink strobes (exprr, expr_l, capp). It sequences the dispensing hardware through timed phases: cup drop, grind, water and, for cappuccino only, milk. It reports busy and done back to the vending side. A one-deep pending slot accepts a strobe that arrives mid-brew.

Parameters:
CNT_W, 8, phase counter width; every phase parameter must satisfy 1 <= value <= 2^CNT_W.
CUP_CYC, 2, cycles cup_drop is asserted.
GRIND_CYC, 3, cycles grind is asserted.
WATER_SHORT, 4, water cycles for espresso and cappuccino.
WATER_LONG, 8, water cycles for long espresso.
MILK_CYC, 5, milk cycles (cappuccino only).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
exprr  input  1  one-cycle espresso request strobe.
expr_l  input  1  one-cycle long-espresso request strobe.
capp  input  1  one-cycle cappuccino request strobe.
busy  output  1  high whenever state != IDLE.
cup_drop  output  1  cup actuator.
grind  output  1  grinder motor.
pump_water  output  1  water pump.
pump_milk  output  1  milk pump.
drink  output  2  drink being served: 01 espresso, 10 long, 11 cappuccino, 00 idle.
done  output  1  one-cycle pulse when a drink completes.
overflow  output  1  one-cycle pulse when a request is dropped.

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, pending slot empty; every output 0.
- Outputs are decoded from registered state only (Moore); no input-to-output combinational path.
- Request decode: any strobe high = request. Simultaneous strobes use priority capp > expr_l > exprr; lower-priority strobes are discarded silently.
- States:
  - IDLE:
    - On request, latch drink code, load counter = CUP_CYC-1, go to CUP.
    - Request sampled at edge t gives cup_drop high from cycle t+1.
  - CUP:
    - cup_drop=1.
    - When counter==0, load GRIND_CYC-1 and go to GRIND; otherwise decrement.
  - GRIND:
    - grind=1.
    - When counter==0, load WATER_LONG-1 if drink==10, else WATER_SHORT-1; go to WATER.
  - WATER:
    - pump_water=1.
    - When counter==0: capp goes to MILK (load MILK_CYC-1); others go to DONE.
  - MILK:
    - pump_milk=1.
    - When counter==0, go to DONE.
  - DONE (exactly 1 cycle):
    - done=1, busy=1.
    - If pending is full: move the pending drink to the active drink, clear pending, load CUP_CYC-1, go to CUP.
    - Otherwise go to IDLE.
- Each phase lasts exactly its parameter in cycles.
- Total busy time = CUP+GRIND+WATER(+MILK)+1.
- drink holds the active code from CUP through DONE; it is 00 in IDLE.
- Pending slot:
  - Request while state != IDLE with pending empty: latch code (after priority).
  - Request while pending full: drop it and pulse overflow for 1 cycle; the pending contents are unchanged.
  - Request in the DONE cycle while pending is full: the pending entry is consumed and the new request fills the freed slot; no overflow.
- No request is lost in IDLE, and busy never drops between back-to-back drinks served from pending.

Optional Feature:
CUP_SENSE_EN
- Defined:
  - Adds input cup_present (1 bit) and output fault (1 bit, reset 0).
  - CUP exits only once the counter has reached 0 and cup_present==1.
  - If cup_present stays 0 for 2^CNT_W further cycles, pulse fault for 1 cycle, discard the active drink and go to IDLE.
  - A pending drink is then started on the next cycle as if newly requested.
- Undefined: CUP is fixed-duration, and neither cup_present nor fault exists.

Test Plan:
1. Reset mid-MILK of a cappuccino -> all outputs 0 immediately, pending empty; a later exprr restarts cleanly.
2. Defaults, exprr pulse at edge 0 -> cup_drop cycles 1-2, grind 3-5, pump_water 6-9, done cycle 10, busy low at cycle 11, drink=01 throughout.
3. capp pulse -> pump_water 4 cycles, then pump_milk 5 cycles, done after 15 busy cycles, drink=11.
4. exprr+capp in the same cycle -> cappuccino served; expr_l alone -> pump_water 8 cycles, 14 busy cycles.
5. exprr, then expr_l during GRIND, then capp during WATER -> overflow pulses at capp; after done, cup_drop restarts the cycle after DONE with drink=10, busy continuous.
6. CUP_SENSE_EN, cup_present=0 -> fault pulse after CUP_CYC+256 cycles, IDLE, no grind; cup_present=1 at cycle 4 -> grind starts at cycle 5.
